// File: rtl/clk_monitor.sv
// Watches one divided clock in the fast clk domain: edge-enable pulses, rise-to-rise
// period measurement, and lock/fault status with a sticky error flag.
module clk_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 4,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             en,
  input  logic             err_clr,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
  localparam logic [3:0]        LOCK_N  = 4'(LOCK_COUNT);

  state_t            state_r;
  logic              s1, s2, seen_first;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        good_cnt;
  logic              rise_s, fall_s, sat_s, good_s, err_set_s;
  logic signed [CNT_W:0] diff_s, absd_s;

  // Edge detection, tolerance check and the err-set condition.
  always_comb begin
    rise_s = s1 & ~s2;
    fall_s = ~s1 & s2;
    sat_s  = (cnt == CNT_MAX);
    diff_s = $signed({1'b0, cnt}) - EXP_S;
    if (diff_s[CNT_W]) begin
      absd_s = -diff_s;
    end else begin
      absd_s = diff_s;
    end
    good_s = (absd_s <= TOL_S);
    // Losing lock, by a bad period or a stall, is the only way err gets set.
    if (en && (state_r == LOCKED)) begin
      if (rise_s) begin
        err_set_s = ~good_s;
      end else begin
        err_set_s = sat_s;
      end
    end else begin
      err_set_s = 1'b0;
    end
  end

  // Sampling, counting, lock FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0; s2 <= 1'b0;
      cnt <= '0; good_cnt <= 4'd0; seen_first <= 1'b0;
      state_r <= IDLE;
      rise_pulse <= 1'b0; fall_pulse <= 1'b0;
      period <= '0; period_valid <= 1'b0;
      locked <= 1'b0; err <= 1'b0;
    end else begin
      s1 <= slow_clk;
      s2 <= s1;
      if (err_set_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (!en) begin
        // Soft clear; sampling keeps running so re-enable sees no fake edge.
        state_r <= IDLE;
        cnt <= '0; good_cnt <= 4'd0; seen_first <= 1'b0;
        locked <= 1'b0; period_valid <= 1'b0;
        rise_pulse <= 1'b0; fall_pulse <= 1'b0;
      end else begin
        rise_pulse   <= rise_s;
        fall_pulse   <= fall_s;
        period_valid <= 1'b0;
        if (rise_s) begin
          cnt <= CNT_ONE;
        end else if (!sat_s) begin
          cnt <= cnt + CNT_ONE;
        end
        if (rise_s && seen_first) begin
          period       <= cnt;
          period_valid <= 1'b1;
        end
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              state_r    <= ACQ;
              seen_first <= 1'b1;
              good_cnt   <= 4'd0;
            end
          end
          ACQ: begin
            if (rise_s) begin
              if (good_s) begin
                good_cnt <= good_cnt + 4'd1;
                if ((good_cnt + 4'd1) == LOCK_N) begin
                  state_r <= LOCKED;
                  locked  <= 1'b1;
                end
              end else begin
                good_cnt <= 4'd0;
              end
            end else if (sat_s) begin
              state_r <= IDLE; seen_first <= 1'b0;
              locked <= 1'b0; good_cnt <= 4'd0;
            end
          end
          LOCKED: begin
            if (rise_s) begin
              if (!good_s) begin
                state_r <= ACQ; locked <= 1'b0; good_cnt <= 4'd0;
              end
            end else if (sat_s) begin
              state_r <= IDLE; seen_first <= 1'b0;
              locked <= 1'b0; good_cnt <= 4'd0;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_monitor.sv
// Bench for clk_monitor: table of slow-clock phases with expected status, a period
// scoreboard fed by the driver, and hand sequences for latency/en/rst/set-wins cases.
module tb_clk_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slow_clk = 1'b0;
  logic en = 1'b1;
  logic err_clr = 1'b0;
  logic rise_pulse, fall_pulse, period_valid, locked, err;
  logic [7:0] period;
  logic t_rise, t_fall, t_pv, t_locked, t_err;
  logic [7:0] t_period;

  clk_monitor #(.CNT_W(8), .EXP_PERIOD(4), .TOL(0), .LOCK_COUNT(4)) dut (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .en(en), .err_clr(err_clr),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .period(period),
    .period_valid(period_valid), .locked(locked), .err(err)
  );

  clk_monitor #(.CNT_W(8), .EXP_PERIOD(4), .TOL(1), .LOCK_COUNT(4)) dut_t (
    .clk(clk), .rst(rst), .slow_clk(slow_clk), .en(en), .err_clr(err_clr),
    .rise_pulse(t_rise), .fall_pulse(t_fall), .period(t_period),
    .period_valid(t_pv), .locked(t_locked), .err(t_err)
  );

  always #5 clk = ~clk;

  typedef enum int {H_NONE, H_LATENCY, H_LOCKEDGE, H_CLR_RST, H_STALL} hook_t;
  typedef struct {
    hook_t hook;
    int    hi, lo, n;
    int    exp_locked, exp_err, exp_period;
  } row_t;

  row_t rows[12];
  int   tests = 0, fails = 0;
  int   cyc = 0, last_rise = 0;
  int   rise_cnt = 0, fall_cnt = 0;
  bit   tb_seen = 1'b0;
  int   exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    cyc++;
    if (rise_pulse) rise_cnt++;
    if (fall_pulse) fall_cnt++;
    if (period_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL strobe_unexpected: period=%0d with no strobe expected (cycle %0d)", period, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_period", int'(period), e);
      end
    end
  endtask

  task automatic set_slow(input logic v);
    if (v && !slow_clk && !rst && en) begin
      if (tb_seen) exp_q.push_back(cyc - last_rise);
      tb_seen   = 1'b1;
      last_rise = cyc;
    end
    slow_clk = v;
  endtask

  task automatic run(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      set_slow(1'b1);
      repeat (hi) tick();
      set_slow(1'b0);
      repeat (lo) tick();
    end
  endtask

  task automatic do_hook(input hook_t h);
    case (h)
      H_LATENCY: begin
        set_slow(1'b1);
        tick(); chk("rise_lat_e1", rise_pulse, 0);
        tick(); chk("rise_lat_e2", rise_pulse, 1);
        set_slow(1'b0);
        tick(); chk("rise_lat_e3", rise_pulse, 0); chk("fall_lat_e1", fall_pulse, 0);
        tick(); chk("fall_lat_e2", fall_pulse, 1);
      end
      H_LOCKEDGE: begin
        set_slow(1'b1);
        tick(); chk("lock_before", locked, 0);
        tick(); chk("lock_pv", period_valid, 1); chk("lock_same_edge", locked, 1);
        set_slow(1'b0);
        tick(); tick();
      end
      H_CLR_RST: begin
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("err_clr", err, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        tb_seen = 1'b0;
      end
      H_STALL: begin
        repeat (300) tick();
        tb_seen = 1'b0;
        chk("stall_locked", locked, 0);
        chk("stall_err", err, 1);
        chk("stall_period_hold", period, 4);
      end
      default: ;
    endcase
  endtask

  initial begin
    int r0, f0;
    rows[0]  = '{H_LATENCY,  2, 2, 3, 0, 0, 4};
    rows[1]  = '{H_LOCKEDGE, 2, 2, 2, 1, 0, 4};
    rows[2]  = '{H_NONE,     3, 2, 1, 1, 0, 4};
    rows[3]  = '{H_NONE,     2, 2, 1, 0, 1, 5};
    rows[4]  = '{H_NONE,     2, 2, 3, 0, 1, 4};
    rows[5]  = '{H_NONE,     2, 2, 1, 1, 1, 4};
    rows[6]  = '{H_CLR_RST,  4, 4, 6, 0, 0, 8};
    rows[7]  = '{H_NONE,     2, 2, 1, 0, 0, 8};
    rows[8]  = '{H_NONE,     2, 2, 4, 1, 0, 4};
    rows[9]  = '{H_STALL,    2, 2, 1, 0, 1, 4};
    rows[10] = '{H_NONE,     2, 2, 3, 0, 1, 4};
    rows[11] = '{H_NONE,     2, 2, 1, 1, 1, 4};

    // Reset held while slow_clk toggles.
    rst = 1'b1;
    run(2, 2, 1);
    chk("rst_rise", rise_pulse, 0); chk("rst_fall", fall_pulse, 0);
    chk("rst_period", period, 0);   chk("rst_pv", period_valid, 0);
    chk("rst_locked", locked, 0);   chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_hook(rows[i].hook);
      r0 = rise_cnt; f0 = fall_cnt;
      run(rows[i].hi, rows[i].lo, rows[i].n);
      chk($sformatf("row%0d_rises", i), rise_cnt - r0, rows[i].n);
      chk($sformatf("row%0d_falls", i), fall_cnt - f0, rows[i].n);
      chk($sformatf("row%0d_locked", i), locked, rows[i].exp_locked);
      chk($sformatf("row%0d_err", i), err, rows[i].exp_err);
      chk($sformatf("row%0d_period", i), period, rows[i].exp_period);
    end

    // Drop en while locked with slow_clk high, then re-enable while still high.
    set_slow(1'b1); tick(); tick();
    en = 1'b0; tb_seen = 1'b0;
    tick();
    chk("en_locked", locked, 0); chk("en_pv", period_valid, 0);
    chk("en_period_hold", period, 4); chk("en_err_hold", err, 1);
    repeat (3) tick();
    en = 1'b1;
    r0 = rise_cnt;
    repeat (3) tick();
    chk("reen_no_rise", rise_cnt - r0, 0);
    set_slow(1'b0); tick(); tick();
    set_slow(1'b1);
    tick(); chk("reen_rise_e1", rise_pulse, 0);
    tick(); chk("reen_rise_e2", rise_pulse, 1);
    set_slow(1'b0); tick(); tick();

    // Reset in the middle of acquisition.
    run(2, 2, 2);
    rst = 1'b1; tick();
    chk("mid_rst_locked", locked, 0); chk("mid_rst_err", err, 0);
    chk("mid_rst_period", period, 0); chk("mid_rst_pv", period_valid, 0);
    chk("mid_rst_rise", rise_pulse, 0); chk("mid_rst_fall", fall_pulse, 0);
    rst = 1'b0; tb_seen = 1'b0;
    tick();

    // Alternating periods 3 and 5: locks only with TOL=1.
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) run(1, 2, 1);
      else            run(2, 3, 1);
    end
    chk("tol1_locked", t_locked, 1);
    chk("tol1_period", t_period, 5);
    chk("tol0_locked", locked, 0);
    run(4, 3, 1);
    set_slow(1'b1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_wins_err", t_err, 1);
    chk("set_wins_locked", t_locked, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("tol1_err_clr", t_err, 0);
    set_slow(1'b0);
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
